// File: rtl/pbch_descrambler_pkg.sv
// Shared postFFT definitions: PBCH block constants, descrambler state type and
// the Gold-sequence LFSR tap steps used by every descrambler in the chain.
package pbch_descrambler_pkg;

    localparam int PBCH_M_BIT = 864;
    localparam int GOLD_NC    = 1600;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_STREAM
    } pbch_state_t;

    // x[0] is x(n); the new bit x(n+31) enters at the top as the register shifts right
    function automatic logic [30:0] gold_x1_step(input logic [30:0] x);
        return {x[3] ^ x[0], x[30:1]};
    endfunction

    function automatic logic [30:0] gold_x2_step(input logic [30:0] x);
        return {x[3] ^ x[2] ^ x[1] ^ x[0], x[30:1]};
    endfunction

endpackage

// File: rtl/pbch_descrambler_gold_seq_gen.sv
// NR Gold-sequence generator: loadable x1/x2 LFSR pair, one step per enabled
// cycle, current sequence bit c = x1(n) ^ x2(n).
module gold_seq_gen
    import pbch_descrambler_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [30:0] c_init,
    output logic        c
);

    logic [30:0] x1;
    logic [30:0] x2;

    // load wins over step so a restart always begins from a clean seed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x1 <= '0;
            x2 <= '0;
        end else if (load) begin
            x1 <= 31'h1;
            x2 <= c_init;
        end else if (step) begin
            x1 <= gold_x1_step(x1);
            x2 <= gold_x2_step(x2);
        end
    end

    assign c = x1[0] ^ x2[0];

endmodule

// File: rtl/pbch_descrambler.sv
// Bit-serial PBCH descrambler: warms the Gold sequence up to NC + v*M_BIT,
// then XORs M_BIT accepted input bits with c(n) into a registered serial output.
module pbch_descrambler
    import pbch_descrambler_pkg::*;
#(
    parameter int M_BIT     = PBCH_M_BIT,
    parameter int NC        = GOLD_NC,
    parameter int V_WIDTH   = 3,
    parameter int CID_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CID_WIDTH-1:0] cell_id,
    input  logic [V_WIDTH-1:0]   v,
    input  logic                 serial_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 serial_out,
    output logic                 out_valid,
    output logic                 done,
    output logic                 busy
);

    pbch_state_t state;
    logic [13:0] wcnt;
    logic [9:0]  bcnt;
    logic [13:0] w_init;
    logic        accept;
    logic        last_bit;
    logic        c;

    assign accept   = (state == ST_STREAM) && in_valid;
    assign last_bit = (bcnt == 10'(M_BIT - 1));
    assign w_init   = 14'(NC) + 14'(v) * 14'(M_BIT);
    assign in_ready = (state == ST_STREAM);
    assign busy     = (state != ST_IDLE);

    gold_seq_gen u_gold (
        .clk    (clk),
        .rst    (rst),
        .load   (start),
        .step   ((state == ST_WARMUP) || accept),
        .c_init (31'(cell_id)),
        .c      (c)
    );

    // The output path runs independently of start, so a bit accepted on the
    // restart cycle (including the final one, with its done) is still emitted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            wcnt       <= '0;
            bcnt       <= '0;
            serial_out <= 1'b0;
            out_valid  <= 1'b0;
            done       <= 1'b0;
        end else begin
            out_valid <= accept;
            done      <= accept && last_bit;
            if (accept) begin
                serial_out <= serial_in ^ c;
            end
            if (start) begin
                state <= ST_WARMUP;
                wcnt  <= w_init;
                bcnt  <= '0;
            end else begin
                case (state)
                    ST_WARMUP: begin
                        wcnt <= wcnt - 14'd1;
                        if (wcnt == 14'd1) begin
                            state <= ST_STREAM;
                        end
                    end
                    ST_STREAM: begin
                        if (in_valid) begin
                            if (last_bit) begin
                                bcnt  <= '0;
                                state <= ST_IDLE;
                            end else begin
                                bcnt <= bcnt + 10'd1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
